// File: rtl/mult_div_unit.sv
// Sequential radix-2 multiply / restoring divide unit with Hi/Lo.
// Serves MULT, MULTU, DIV, DIVU plus MTHI/MTLO writes.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE, PREP, RUN, FIX
  } state_t;

  state_t state, next;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, opnd, rem;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               sign_q, sign_r;

  logic               is_sgn, is_div, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;

  // Op[0] clear selects the signed variant.
  always_comb begin
    is_sgn  = ~op_q[0];
    is_div  = op_q[1];
    b_zero  = (b_q == '0);
    mag_a   = (is_sgn && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b   = (is_sgn && b_q[WIDTH-1]) ? -b_q : b_q;
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + {1'b0, opnd};
    shifted = {rem, acc[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    prod    = sign_q ? -acc : acc;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (Start) next = PREP;
      PREP: next = (is_div && b_zero) ? FIX : RUN;
      RUN:  if (cnt == CW'(1)) next = FIX;
      FIX:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd    <= '0;
      rem     <= '0;
      acc     <= '0;
      cnt     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            op_q    <= Op;
            a_q     <= A;
            b_q     <= B;
            DivZero <= 1'b0;
          end else begin
            if (HiWrite) Hi <= WrData;
            if (LoWrite) Lo <= WrData;
          end
        end
        PREP: begin
          opnd   <= is_div ? mag_b : mag_a;
          acc    <= {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
          rem    <= '0;
          cnt    <= CW'(WIDTH);
          sign_q <= is_sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          sign_r <= is_sgn & a_q[WIDTH-1];
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (!is_div) begin
            // Carry out of the add shifts into the accumulator MSB.
            if (acc[0]) acc <= {sum, acc[WIDTH-1:1]};
            else        acc <= {1'b0, acc[2*WIDTH-1:1]};
          end else if (!diff[WIDTH]) begin
            rem             <= diff[WIDTH-1:0];
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b1};
          end else begin
            rem             <= shifted[WIDTH-1:0];
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          Done <= 1'b1;
          if (!is_div) begin
            Hi <= prod[2*WIDTH-1:WIDTH];
            Lo <= prod[WIDTH-1:0];
          end else if (b_zero) begin
            Hi      <= a_q;
            Lo      <= '1;
            DivZero <= 1'b1;
          end else begin
            Lo <= sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            Hi <= sign_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH 32 and 8 instances).
// Expected values are hand-computed constants.
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = '0;
  logic [31:0] A = '0, B = '0, WrData = '0;
  logic        HiWrite = 1'b0, LoWrite = 1'b0;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  logic        S8 = 1'b0;
  logic [1:0]  Op8 = '0;
  logic [7:0]  A8 = '0, B8 = '0;
  logic        Busy8, Done8, Dz8;
  logic [7:0]  Hi8, Lo8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .A(A), .B(B), .HiWrite(HiWrite), .LoWrite(LoWrite),
    .WrData(WrData), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Start(S8), .Op(Op8),
    .A(A8), .B(B8), .HiWrite(1'b0), .LoWrite(1'b0),
    .WrData(8'h00), .Busy(Busy8), .Done(Done8),
    .DivZero(Dz8), .Hi(Hi8), .Lo(Lo8)
  );

  task automatic start_op(input logic [1:0] op,
                          input logic [31:0] a, b);
    @(posedge Clk); #1;
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bsy);
    cyc = -1;
    bsy = Busy ? 1 : 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge Clk); #1;
      if (Done) begin
        cyc = i;
        break;
      end
      if (Busy) bsy++;
    end
    if (cyc < 0) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: no Done in 100 cycles");
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge Clk);
    #1;
    n_cmp++;
    if ({Busy, Done, DivZero} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000",
               {Busy, Done, DivZero});
    end
    n_cmp++;
    if ({Hi, Lo} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_hilo: got %h want 0", {Hi, Lo});
    end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_mult;
    int c, b;
    start_op(2'b00, 32'hFFFFFFFD, 32'd7);
    wait_done(c, b);
    n_cmp++;
    if ({Hi, Lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
      n_err++;
      $display("FAIL mult_neg: got %h want ffffffffffffffeb",
               {Hi, Lo});
    end
    n_cmp++;
    if (c !== 34) begin
      n_err++;
      $display("FAIL mult_latency: got %0d want 34", c);
    end
    n_cmp++;
    if (b !== 34) begin
      n_err++;
      $display("FAIL mult_busy: got %0d want 34", b);
    end
    n_cmp++;
    if (Busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_in_done: got %b want 0", Busy);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if (Done !== 1'b0) begin
      n_err++;
      $display("FAIL done_width: got %b want 0", Done);
    end
  endtask

  task automatic test_mult_ones;
    int c, b;
    start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(c, b);
    n_cmp++;
    if ({Hi, Lo} !== 64'hFFFFFFFE_00000001) begin
      n_err++;
      $display("FAIL multu_max: got %h want fffffffe00000001",
               {Hi, Lo});
    end
    start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(c, b);
    n_cmp++;
    if ({Hi, Lo} !== 64'h1) begin
      n_err++;
      $display("FAIL mult_m1m1: got %h want 1", {Hi, Lo});
    end
  endtask

  task automatic test_div;
    int c, b;
    start_op(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(c, b);
    n_cmp++;
    if ({Hi, Lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
      n_err++;
      $display("FAIL div_neg: got %h want ffffffff_fffffffd",
               {Hi, Lo});
    end
    n_cmp++;
    if (c !== 34) begin
      n_err++;
      $display("FAIL div_latency: got %0d want 34", c);
    end
    start_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(c, b);
    n_cmp++;
    if ({Hi, Lo} !== 64'h00000000_80000000) begin
      n_err++;
      $display("FAIL div_min_m1: got %h want 0_80000000",
               {Hi, Lo});
    end
  endtask

  task automatic test_div_zero;
    int c, b;
    start_op(2'b11, 32'h1234, 32'd0);
    wait_done(c, b);
    n_cmp++;
    if (c !== 2) begin
      n_err++;
      $display("FAIL dz_latency: got %0d want 2", c);
    end
    n_cmp++;
    if (DivZero !== 1'b1) begin
      n_err++;
      $display("FAIL dz_flag: got %b want 1", DivZero);
    end
    n_cmp++;
    if ({Hi, Lo} !== 64'h00001234_FFFFFFFF) begin
      n_err++;
      $display("FAIL dz_hilo: got %h want 1234_ffffffff",
               {Hi, Lo});
    end
    start_op(2'b11, 32'd7, 32'd2);
    n_cmp++;
    if (DivZero !== 1'b0) begin
      n_err++;
      $display("FAIL dz_clear: got %b want 0", DivZero);
    end
    wait_done(c, b);
    n_cmp++;
    if ({Hi, Lo} !== 64'h00000001_00000003) begin
      n_err++;
      $display("FAIL divu_7_2: got %h want 1_3", {Hi, Lo});
    end
  endtask

  task automatic test_hilo_write;
    @(posedge Clk); #1;
    HiWrite = 1'b1; WrData = 32'hCAFEBABE;
    @(posedge Clk); #1;
    HiWrite = 1'b0;
    n_cmp++;
    if (Hi !== 32'hCAFEBABE) begin
      n_err++;
      $display("FAIL mthi: got %h want cafebabe", Hi);
    end
    LoWrite = 1'b1; WrData = 32'h12345678;
    @(posedge Clk); #1;
    LoWrite = 1'b0;
    n_cmp++;
    if (Lo !== 32'h12345678) begin
      n_err++;
      $display("FAIL mtlo: got %h want 12345678", Lo);
    end
  endtask

  task automatic test_busy_ignore;
    int c, b;
    start_op(2'b01, 32'd3, 32'd5);
    repeat (5) @(posedge Clk);
    #1;
    n_cmp++;
    if ({Hi, Lo} !== 64'hCAFEBABE_12345678) begin
      n_err++;
      $display("FAIL hold_mid: got %h want cafebabe_12345678",
               {Hi, Lo});
    end
    Start = 1'b1; Op = 2'b10; A = 32'd9; B = 32'd0;
    HiWrite = 1'b1; LoWrite = 1'b1; WrData = 32'hFFFF0000;
    @(posedge Clk); #1;
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    wait_done(c, b);
    n_cmp++;
    if ({Hi, Lo} !== 64'h0000000F) begin
      n_err++;
      $display("FAIL busy_ignore: got %h want f", {Hi, Lo});
    end
    n_cmp++;
    if (c !== 28) begin
      n_err++;
      $display("FAIL busy_restart: got %0d want 28", c);
    end
  endtask

  task automatic test_start_lowrite;
    int c, b;
    @(posedge Clk); #1;
    Start = 1'b1; Op = 2'b11; A = 32'd100; B = 32'd7;
    LoWrite = 1'b1; WrData = 32'hDEADBEEF;
    @(posedge Clk); #1;
    Start = 1'b0; LoWrite = 1'b0;
    n_cmp++;
    if (Lo !== 32'h0000000F) begin
      n_err++;
      $display("FAIL start_wins: got %h want f", Lo);
    end
    wait_done(c, b);
    n_cmp++;
    if ({Hi, Lo} !== 64'h00000002_0000000E) begin
      n_err++;
      $display("FAIL divu_100_7: got %h want 2_e", {Hi, Lo});
    end
  endtask

  task automatic test_back_to_back;
    int c, b;
    start_op(2'b01, 32'd6, 32'd7);
    wait_done(c, b);
    n_cmp++;
    if (Lo !== 32'd42) begin
      n_err++;
      $display("FAIL b2b_first: got %h want 2a", Lo);
    end
    Start = 1'b1; Op = 2'b01; A = 32'd2; B = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0;
    n_cmp++;
    if ({Busy, Done} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_accept: got %b want 10", {Busy, Done});
    end
    wait_done(c, b);
    n_cmp++;
    if (Lo !== 32'd6 || c !== 34) begin
      n_err++;
      $display("FAIL b2b_second: got %h/%0d want 6/34", Lo, c);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    start_op(2'b00, 32'd5, 32'd5);
    repeat (9) @(posedge Clk);
    #3;
    Reset = 1'b0;
    #1;
    n_cmp++;
    if ({Busy, Done, Hi, Lo} !== 66'h0) begin
      n_err++;
      $display("FAIL abort_clear: got %b %b %h %h want 0",
               Busy, Done, Hi, Lo);
    end
    @(negedge Clk);
    Reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Done || Busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL abort_nodone: got %0d want 0", seen);
    end
  endtask

  task automatic test_width8;
    int c;
    c = -1;
    @(posedge Clk); #1;
    S8 = 1'b1; Op8 = 2'b00; A8 = 8'h80; B8 = 8'h80;
    @(posedge Clk); #1;
    S8 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk); #1;
      if (Done8) begin
        c = i;
        break;
      end
    end
    n_cmp++;
    if (c !== 10) begin
      n_err++;
      $display("FAIL w8_latency: got %0d want 10", c);
    end
    n_cmp++;
    if ({Hi8, Lo8} !== 16'h4000) begin
      n_err++;
      $display("FAIL w8_mult: got %h want 4000", {Hi8, Lo8});
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_mult_ones;
    test_div;
    test_div_zero;
    test_hilo_write;
    test_busy_ignore;
    test_start_lowrite;
    test_back_to_back;
    test_reset_abort;
    test_width8;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
